// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue -- two-stage issue/capture wrapper around an external
// combinational ALU.
//
// S1 (issue registers) drives alu_a/alu_b/alu_func toward the external ALU.
// S2 captures the ALU response (alu_y/alu_flags) into out_y/out_flags under a
// valid/ready handshake. The architectural flag register fr is loaded from
// the ALU flags when an op that requested it leaves S1.
//
// Optional feature macro: ALU_ISSUE_FWD_EN
//   When defined, in_fwd_a/in_fwd_b replace the corresponding operand with
//   the previous op's result. Without it those inputs are ignored.
//
// Widths come from DATA_W, ALU_FUNC_W and FR_FLAG_W (defaults below apply
// only when no definitions file has provided them).
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    upstream op handshake
//   in_a, in_b, in_func    operands and ALU function code
//   in_fr_we               op updates the flag register
//   in_fwd_a, in_fwd_b     operand forwarding selects
//   alu_a, alu_b, alu_func registered drive to the external ALU
//   alu_y, alu_flags       combinational ALU response
//   out_valid / out_ready  downstream handshake
//   out_y, out_flags       captured result and flags
//   fr                     architectural flag register
// -----------------------------------------------------------------------------
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef ALU_FUNC_W
`define ALU_FUNC_W 4
`endif
`ifndef FR_FLAG_W
`define FR_FLAG_W 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif
`ifndef ALU_AND
`define ALU_AND 4'd3
`endif

module alu_issue (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [`DATA_W-1:0]     in_a,
    input  logic [`DATA_W-1:0]     in_b,
    input  logic [`ALU_FUNC_W-1:0] in_func,
    input  logic                   in_fr_we,
    input  logic                   in_fwd_a,
    input  logic                   in_fwd_b,
    output logic [`DATA_W-1:0]     alu_a,
    output logic [`DATA_W-1:0]     alu_b,
    output logic [`ALU_FUNC_W-1:0] alu_func,
    input  logic [`DATA_W-1:0]     alu_y,
    input  logic [`FR_FLAG_W-1:0]  alu_flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [`DATA_W-1:0]     out_y,
    output logic [`FR_FLAG_W-1:0]  out_flags,
    output logic [`FR_FLAG_W-1:0]  fr
);

    // S1 state
    logic                   s1_valid_reg;
    logic                   s1_fr_we_reg;
    logic [`DATA_W-1:0]     alu_a_reg;
    logic [`DATA_W-1:0]     alu_b_reg;
    logic [`ALU_FUNC_W-1:0] alu_func_reg;

    // S2 state
    logic                   out_valid_reg;
    logic [`DATA_W-1:0]     out_y_reg;
    logic [`FR_FLAG_W-1:0]  out_flags_reg;
    logic [`FR_FLAG_W-1:0]  fr_reg;

    logic                   s1_adv;
    logic                   accept;
    logic [`DATA_W-1:0]     op_a;
    logic [`DATA_W-1:0]     op_b;

    // S1 moves into S2 whenever S2 is empty or is being drained this cycle.
    assign s1_adv   = s1_valid_reg && (!out_valid_reg || out_ready);
    // Independent of in_valid so upstream can wait on in_ready freely.
    assign in_ready = !s1_valid_reg || s1_adv;
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_FWD_EN
    // Result of the most recent op that left S1 (mirrors out_y loads).
    logic [`DATA_W-1:0] last_y_reg;
    logic [`DATA_W-1:0] fwd_y;

    // If the previous op is still in S1 it is advancing this very cycle
    // (otherwise accept could not happen), so its result is on alu_y.
    assign fwd_y = s1_valid_reg ? alu_y : last_y_reg;
    assign op_a  = in_fwd_a ? fwd_y : in_a;
    assign op_b  = in_fwd_b ? fwd_y : in_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_y_reg <= '0;
        end else if (s1_adv) begin
            last_y_reg <= alu_y;
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = in_fwd_a | in_fwd_b;
    assign op_a       = in_a;
    assign op_b       = in_b;
`endif

    // S1: operand registers only change on accept, so the ALU inputs stay
    // quiet while idle or stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_fr_we_reg <= 1'b0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            alu_func_reg <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_fr_we_reg <= in_fr_we;
            alu_a_reg    <= op_a;
            alu_b_reg    <= op_b;
            alu_func_reg <= in_func;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // S2: capture ALU response on advance; clear once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_flags_reg <= '0;
        end else if (s1_adv) begin
            out_valid_reg <= 1'b1;
            out_y_reg     <= alu_y;
            out_flags_reg <= alu_flags;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Architectural flags follow ops in issue order, at the S1->S2 transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fr_reg <= '0;
        end else if (s1_adv && s1_fr_we_reg) begin
            fr_reg <= alu_flags;
        end
    end

    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_func  = alu_func_reg;
    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign out_flags = out_flags_reg;
    assign fr        = fr_reg;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue -- self-checking bench for alu_issue.
// Models the external ALU (flags {V,C,N,Z}), drives directed op sequences and
// a randomised back-pressure run, and checks results through a scoreboard
// filled at accept time and drained when the DUT presents output.
// -----------------------------------------------------------------------------
`ifndef DATA_W
`define DATA_W 16
`endif
`ifndef ALU_FUNC_W
`define ALU_FUNC_W 4
`endif
`ifndef FR_FLAG_W
`define FR_FLAG_W 4
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'd1
`endif
`ifndef ALU_SLL
`define ALU_SLL 4'd2
`endif
`ifndef ALU_AND
`define ALU_AND 4'd3
`endif

module tb_alu_issue;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [`DATA_W-1:0]     in_a;
    logic [`DATA_W-1:0]     in_b;
    logic [`ALU_FUNC_W-1:0] in_func;
    logic                   in_fr_we;
    logic                   in_fwd_a;
    logic                   in_fwd_b;
    logic [`DATA_W-1:0]     alu_a;
    logic [`DATA_W-1:0]     alu_b;
    logic [`ALU_FUNC_W-1:0] alu_func;
    logic [`DATA_W-1:0]     alu_y;
    logic [`FR_FLAG_W-1:0]  alu_flags;
    logic                   out_valid;
    logic                   out_ready;
    logic [`DATA_W-1:0]     out_y;
    logic [`FR_FLAG_W-1:0]  out_flags;
    logic [`FR_FLAG_W-1:0]  fr;

    typedef struct packed {
        logic [`DATA_W-1:0]    y;
        logic [`FR_FLAG_W-1:0] f;
    } exp_t;

    exp_t                  sb[$];
    int                    checks = 0;
    int                    errors = 0;
    int                    n_out  = 0;
    logic [`DATA_W-1:0]    prev_y = '0;
    logic [`FR_FLAG_W-1:0] exp_fr = '0;
    logic                  rand_rdy = 1'b0;
    logic                  stall_prev = 1'b0;
    logic [`DATA_W-1:0]    hold_y = '0;
    logic [`FR_FLAG_W-1:0] hold_f = '0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_func   (in_func),
        .in_fr_we  (in_fr_we),
        .in_fwd_a  (in_fwd_a),
        .in_fwd_b  (in_fwd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_func  (alu_func),
        .alu_y     (alu_y),
        .alu_flags (alu_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .fr        (fr)
    );

    // Reference ALU: returns {flags, y}, flags = {V, C, N, Z}.
    function automatic logic [`FR_FLAG_W+`DATA_W-1:0] ref_alu(
        input logic [`DATA_W-1:0] a, input logic [`DATA_W-1:0] b,
        input logic [`ALU_FUNC_W-1:0] f);
        logic [`DATA_W:0]   t;
        logic [`DATA_W-1:0] y;
        logic               c;
        logic               v;
        t = '0; y = '0; c = 1'b0; v = 1'b0;
        case (f)
            `ALU_ADD: begin
                t = {1'b0, a} + {1'b0, b};
                y = t[`DATA_W-1:0];
                c = t[`DATA_W];
                v = (a[`DATA_W-1] == b[`DATA_W-1]) && (y[`DATA_W-1] != a[`DATA_W-1]);
            end
            `ALU_SUB: begin
                t = {1'b0, a} - {1'b0, b};
                y = t[`DATA_W-1:0];
                c = t[`DATA_W];
                v = (a[`DATA_W-1] != b[`DATA_W-1]) && (y[`DATA_W-1] != a[`DATA_W-1]);
            end
            `ALU_SLL: y = a << b[3:0];
            `ALU_AND: y = a & b;
            default:  y = '0;
        endcase
        return {v, c, y[`DATA_W-1], (y == '0), y};
    endfunction

    // External combinational ALU.
    always_comb begin
        {alu_flags, alu_y} = ref_alu(alu_a, alu_b, alu_func);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard drain and hold-stability check, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_y", 32'(out_y), 32'(hold_y));
                chk("hold_flags", 32'(out_flags), 32'(hold_f));
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_y", 32'(out_y), 32'(e.y));
                    chk("sb_flags", 32'(out_flags), 32'(e.f));
                    $display("out: y=%h flags=%b (exp y=%h flags=%b)", out_y, out_flags, e.y, e.f);
                end
            end
            stall_prev = out_valid && !out_ready;
            hold_y     = out_y;
            hold_f     = out_flags;
        end
    end

    // Random back-pressure, applied just after each rising edge.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [`DATA_W-1:0] a, input logic [`DATA_W-1:0] b,
                        input logic [`ALU_FUNC_W-1:0] f, input logic we,
                        input logic fa, input logic fb);
        logic [`DATA_W-1:0]                oa;
        logic [`DATA_W-1:0]                ob;
        logic [`FR_FLAG_W+`DATA_W-1:0]     r;
        bit                                done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_func  = f;
        in_fr_we = we;
        in_fwd_a = fa;
        in_fwd_b = fb;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                oa = a;
                ob = b;
`ifdef ALU_ISSUE_FWD_EN
                if (fa) oa = prev_y;
                if (fb) ob = prev_y;
`endif
                r = ref_alu(oa, ob, f);
                sb.push_back('{y: r[`DATA_W-1:0], f: r[`FR_FLAG_W+`DATA_W-1:`DATA_W]});
                prev_y = r[`DATA_W-1:0];
                if (we) exp_fr = r[`FR_FLAG_W+`DATA_W-1:`DATA_W];
                $display("in : a=%h b=%h func=%0d fr_we=%b fwd=%b%b", a, b, f, we, fa, fb);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_fwd_a = 1'b0;
        in_fwd_b = 1'b0;
        chk("accept_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (sb.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    initial begin
        int n0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_func   = '0;
        in_fr_we  = 1'b0;
        in_fwd_a  = 1'b0;
        in_fwd_b  = 1'b0;
        out_ready = 1'b1;

        // Reset values, taking effect without a clock edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_func", 32'(alu_func), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_fr", 32'(fr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Overflowing add, one-cycle latency.
        send(16'h7FFF, 16'h0001, `ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk("lat_valid_early", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("ovf_valid", 32'(out_valid), 32'd1);
        chk("ovf_y", 32'(out_y), 32'h8000);
        chk("ovf_flags", 32'(out_flags), 32'b1010);
        chk("ovf_fr", 32'(fr), 32'b1010);
        drain();

        // Back-to-back ops into a stalled output.
        out_ready = 1'b0;
        send(16'h8000, 16'h0001, `ALU_SUB, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, `ALU_ADD, 1'b1, 1'b0, 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_y", 32'(out_y), 32'h7FFF);
        chk("stall_valid", 32'(out_valid), 32'd1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("stall_y_held", 32'(out_y), 32'h7FFF);
        chk("stall_in_ready_held", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("unstall_y", 32'(out_y), 32'h0000);
        chk("unstall_flags", 32'(out_flags), 32'b0101);
        drain();
        chk("stall_fr", 32'(fr), 32'b0101);

        // Flag write-enable: shift must not disturb fr.
        send(16'h0001, 16'h0001, `ALU_ADD, 1'b1, 1'b0, 1'b0);
        send(16'hF000, 16'h0004, `ALU_SLL, 1'b0, 1'b0, 1'b0);
        drain();
        chk("frwe_fr", 32'(fr), 32'b0000);
        chk("frwe_fr_model", 32'(fr), 32'(exp_fr));

        // Forwarding from an op still in S1, then from the last result.
        send(16'h0003, 16'h0004, `ALU_ADD, 1'b0, 1'b0, 1'b0);
        send(16'h0010, 16'h0001, `ALU_ADD, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
`ifdef ALU_ISSUE_FWD_EN
        chk("fwd_y", 32'(out_y), 32'h0008);
`else
        chk("fwd_y", 32'(out_y), 32'h0011);
`endif
        drain();
        send(16'h0020, 16'h0002, `ALU_ADD, 1'b0, 1'b1, 1'b0);
        drain();

        // Random ops under random back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(16'($urandom), 16'($urandom),
                 `ALU_FUNC_W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        chk("rand_fr", 32'(fr), 32'(exp_fr));

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(16'h1111, 16'h2222, `ALU_SUB, 1'b1, 1'b0, 1'b0);
        send(16'h3333, 16'h4444, `ALU_SUB, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_fr", 32'(fr), 32'd0);
        chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        prev_y = '0;
        exp_fr = '0;
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        send(16'h0005, 16'h0006, `ALU_ADD, 1'b1, 1'b0, 1'b0);
        drain();
        chk("post_rst_outputs", 32'(n_out - n0), 32'd1);
        chk("post_rst_fr", 32'(fr), 32'(exp_fr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
